// File: rtl/spiral_pattern_engine.sv
// Polar-coordinate colour engine for the VGA spiral demo: multi-arm spiral/ring/ray patterns
// with frame-synchronous config shadowing. Define SPIRAL_CLIP_EN to confine the pattern to the inner radii.
module spiral_pattern_engine #(
    parameter int ANGLE_W = 4,
    parameter int RAD_W   = 5,
    parameter int PHASE_W = 8,
    parameter int LAT     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               display_on_in,
    input  logic [ANGLE_W-1:0] angle,
    input  logic [RAD_W-1:0]   radius,
    input  logic [2:0]         speed,
    input  logic               dir,
    input  logic [1:0]         arms,
    input  logic [1:0]         mode,
    input  logic [5:0]         fg_rgb,
    input  logic [5:0]         bg_rgb,
    output logic [1:0]         r,
    output logic [1:0]         g,
    output logic [1:0]         b,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [7:0]         frame_cnt
);

    typedef enum logic [1:0] {
        MODE_SPIRAL = 2'd0,
        MODE_RINGS  = 2'd1,
        MODE_RAYS   = 2'd2,
        MODE_XOR    = 2'd3
    } mode_t;

`ifdef SPIRAL_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    logic               vs_q_reg;
    logic               frame_tick;
    logic [PHASE_W-1:0] phase_reg;
    logic [2:0]         speed_s_reg;
    logic               dir_s_reg;
    logic [1:0]         arms_s_reg;
    logic [1:0]         mode_s_reg;
    logic [5:0]         fg_s_reg;
    logic [5:0]         bg_s_reg;
    logic [7:0]         frame_cnt_reg;

    // Animation is clocked by clk; vsync only provides a one-cycle enable on its falling edge.
    assign frame_tick = vs_q_reg & ~vsync_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q_reg      <= 1'b1;
            phase_reg     <= '0;
            speed_s_reg   <= '0;
            dir_s_reg     <= 1'b0;
            arms_s_reg    <= '0;
            mode_s_reg    <= '0;
            fg_s_reg      <= '0;
            bg_s_reg      <= '0;
            frame_cnt_reg <= '0;
        end else begin
            vs_q_reg <= vsync_in;
            if (frame_tick) begin
                // Phase moves with the shadow captured at the previous tick.
                phase_reg     <= dir_s_reg ? phase_reg - PHASE_W'(speed_s_reg)
                                           : phase_reg + PHASE_W'(speed_s_reg);
                speed_s_reg   <= speed;
                dir_s_reg     <= dir;
                arms_s_reg    <= arms;
                mode_s_reg    <= mode;
                fg_s_reg      <= fg_rgb;
                bg_s_reg      <= bg_rgb;
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
        end
    end

    logic dl_hs;
    logic dl_vs;
    logic dl_on;

    generate
        if (LAT == 0) begin : g_no_delay
            assign dl_hs = hsync_in;
            assign dl_vs = vsync_in;
            assign dl_on = display_on_in;
        end else begin : g_delay
            // Each stage packs {hsync, vsync, display_on}.
            logic [2:0] stage_reg [LAT];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < LAT; i++) stage_reg[i] <= 3'b110;
                end else begin
                    stage_reg[0] <= {hsync_in, vsync_in, display_on_in};
                    for (int i = 1; i < LAT; i++) stage_reg[i] <= stage_reg[i-1];
                end
            end
            assign {dl_hs, dl_vs, dl_on} = stage_reg[LAT-1];
        end
    endgenerate

    logic [ANGLE_W-1:0] phase_off;
    logic [ANGLE_W-1:0] sa;
    logic [ANGLE_W-1:0] adj;
    logic [ANGLE_W-1:0] rl;
    logic [ANGLE_W-1:0] ring_sum;
    logic               hit_spiral;
    logic               hit_rings;
    logic               hit_rays;
    logic               clip;
    logic               hit;

    assign phase_off  = phase_reg[PHASE_W-1 -: ANGLE_W];
    assign sa         = angle << arms_s_reg;
    assign adj        = sa + phase_off;
    assign rl         = radius[ANGLE_W-1:0];
    assign ring_sum   = rl + phase_off;
    assign hit_spiral = (rl == adj);
    assign hit_rings  = ring_sum[ANGLE_W-1];
    assign hit_rays   = adj[ANGLE_W-1];

    generate
        if (RAD_W > ANGLE_W) begin : g_clip
            assign clip = CLIP_EN & (|radius[RAD_W-1:ANGLE_W]);
        end else begin : g_no_clip
            assign clip = 1'b0;
        end
    endgenerate

    always_comb begin
        hit = 1'b0;
        case (mode_t'(mode_s_reg))
            MODE_SPIRAL: hit = hit_spiral;
            MODE_RINGS:  hit = hit_rings;
            MODE_RAYS:   hit = hit_rays;
            MODE_XOR:    hit = hit_spiral ^ hit_rays;
            default:     hit = 1'b0;
        endcase
        if (clip) hit = 1'b0;
    end

    // Packed as {B, G, R}, matching the fg/bg colour fields.
    logic [5:0] rgb_next;
    logic [5:0] rgb_reg;
    logic       hs_out_reg;
    logic       vs_out_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign rgb_next[2*gi +: 2] = !dl_on ? 2'b00
                                       : (hit ? fg_s_reg[2*gi +: 2] : bg_s_reg[2*gi +: 2]);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_reg    <= '0;
            hs_out_reg <= 1'b1;
            vs_out_reg <= 1'b1;
        end else begin
            rgb_reg    <= rgb_next;
            hs_out_reg <= dl_hs;
            vs_out_reg <= dl_vs;
        end
    end

    assign r         = rgb_reg[1:0];
    assign g         = rgb_reg[3:2];
    assign b         = rgb_reg[5:4];
    assign hsync_out = hs_out_reg;
    assign vsync_out = vs_out_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_spiral_pattern_engine.sv
// Directed bench for spiral_pattern_engine: a polar-pattern model checked every cycle,
// plus hand-computed expectations for latency, animation, arms, modes and clipping.
module tb_spiral_pattern_engine;
    localparam int ANGLE_W = 4;
    localparam int RAD_W   = 5;
    localparam int PHASE_W = 8;
    localparam int LAT     = 2;
    localparam int AMOD    = 1 << ANGLE_W;
    localparam int PMOD    = 1 << PHASE_W;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               hsync_in = 1'b1;
    logic               vsync_in = 1'b1;
    logic               display_on_in = 1'b0;
    logic [ANGLE_W-1:0] angle = '0;
    logic [RAD_W-1:0]   radius = '0;
    logic [2:0]         speed = '0;
    logic               dir = 1'b0;
    logic [1:0]         arms = '0;
    logic [1:0]         mode = '0;
    logic [5:0]         fg_rgb = '0;
    logic [5:0]         bg_rgb = '0;
    logic [1:0]         r, g, b;
    logic               hsync_out, vsync_out;
    logic [7:0]         frame_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    spiral_pattern_engine #(
        .ANGLE_W(ANGLE_W), .RAD_W(RAD_W), .PHASE_W(PHASE_W), .LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .display_on_in(display_on_in),
        .angle(angle), .radius(radius), .speed(speed), .dir(dir),
        .arms(arms), .mode(mode), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
        .r(r), .g(g), .b(b), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                         input bit verbose);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            if (verbose) $display("txn %-18s got %0h expected %0h ok", name, act, exp);
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: shadow config, phase and sync history as plain integers.
    int m_phase, m_speed, m_dir, m_arms, m_mode, m_fg, m_bg, m_frame, m_vsq;
    int dq[$];
    logic [5:0] e_rgb;
    logic       e_hs, e_vs;
    logic [7:0] e_frame;
    bit         model_valid = 1'b0;

    function automatic int colour_of(input int c);
        return (c % 4) * 16 + ((c / 4) % 4) * 4 + (c / 16);
    endfunction

    function automatic bit model_hit(input int ang, input int rad, input int ph,
                                     input int ar, input int md);
        int off, adjv, rlv;
        bit spiral, rays, rings, h;
        off    = ph / (PMOD / AMOD);
        adjv   = (ang * (1 << ar) + off) % AMOD;
        rlv    = rad % AMOD;
        spiral = (rlv == adjv);
        rays   = (adjv >= AMOD / 2);
        rings  = (((rlv + off) % AMOD) >= AMOD / 2);
        case (md)
            0:       h = spiral;
            1:       h = rings;
            2:       h = rays;
            default: h = spiral ^ rays;
        endcase
`ifdef SPIRAL_CLIP_EN
        if (rad >= AMOD) h = 1'b0;
`endif
        return h;
    endfunction

    initial begin
        int cur, dl;
        bit tick;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_phase = 0; m_speed = 0; m_dir = 0; m_arms = 0; m_mode = 0;
                m_fg = 0; m_bg = 0; m_frame = 0; m_vsq = 1;
                dq.delete();
                for (int i = 0; i < LAT; i++) dq.push_back(6);
                e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_frame = '0;
            end else begin
                cur = int'(hsync_in) * 4 + int'(vsync_in) * 2 + int'(display_on_in);
                if (LAT == 0) dl = cur;
                else begin
                    dl = dq.pop_front();
                    dq.push_back(cur);
                end
                e_hs = 1'((dl / 4) % 2);
                e_vs = 1'((dl / 2) % 2);
                if (dl % 2 == 1)
                    e_rgb = 6'(colour_of(model_hit(int'(angle), int'(radius), m_phase, m_arms, m_mode)
                                         ? m_fg : m_bg));
                else
                    e_rgb = '0;
                tick  = (m_vsq == 1) && (vsync_in == 1'b0);
                m_vsq = int'(vsync_in);
                if (tick) begin
                    m_phase = m_dir ? (m_phase - m_speed + PMOD) % PMOD : (m_phase + m_speed) % PMOD;
                    m_speed = int'(speed); m_dir = int'(dir); m_arms = int'(arms);
                    m_mode  = int'(mode);  m_fg  = int'(fg_rgb); m_bg = int'(bg_rgb);
                    m_frame = (m_frame + 1) % 256;
                end
                e_frame = 8'(m_frame);
            end
            model_valid = 1'b1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (model_valid)
                check("cycle", {r, g, b, hsync_out, vsync_out, frame_cnt},
                      {e_rgb, e_hs, e_vs, e_frame}, 1'b0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick();
        @(negedge clk);
        vsync_in = 1'b0;
        @(negedge clk);
        vsync_in = 1'b1;
    endtask

    initial begin
        cyc(3);
        check("rst_rgb", {r, g, b}, 0, 1'b1);
        check("rst_hs", hsync_out, 1, 1'b1);
        check("rst_vs", vsync_out, 1, 1'b1);
        check("rst_frame", frame_cnt, 0, 1'b1);
        reset = 1'b0;
        cyc(4);
        check("no_tick_frame", frame_cnt, 0, 1'b1);

        hsync_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hs_latency", hsync_out, (i < 2) ? 1 : 0, 1'b1);
        end
        hsync_in = 1'b1;
        cyc(4);

        fg_rgb = 6'h3f; bg_rgb = 6'h00; arms = 2'd0; mode = 2'd0;
        do_tick();
        cyc(2);
        check("frame_one", frame_cnt, 1, 1'b1);
        angle = 4'd5; radius = 5'd5;
        cyc(4);
        display_on_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("on_latency", {r, g, b}, (i < 2) ? 0 : 'h3f, 1'b1);
        end
        cyc(2);
        check("spiral_hit", {r, g, b}, 'h3f, 1'b1);
        radius = 5'd6;
        cyc(4);
        check("spiral_miss", {r, g, b}, 0, 1'b1);

        speed = 3'd3; dir = 1'b0;
        repeat (3) do_tick();
        cyc(1);
        check("model_phase6", m_phase, 6, 1'b1);
        dir = 1'b1;
        do_tick(); cyc(1);
        check("model_phase9", m_phase, 9, 1'b1);
        do_tick(); cyc(1);
        check("model_phase6b", m_phase, 6, 1'b1);
        speed = 3'd5;
        do_tick();
        speed = 3'd7; dir = 1'b0;
        do_tick(); cyc(1);
        check("model_phase254", m_phase, 254, 1'b1);
        angle = 4'd6; radius = 5'd5;
        cyc(4);
        check("phase_off15_hit", {r, g, b}, 'h3f, 1'b1);
        angle = 4'd5;
        cyc(4);
        check("phase_off15_miss", {r, g, b}, 0, 1'b1);
        do_tick(); cyc(1);
        check("model_wrap5", m_phase, 5, 1'b1);
        cyc(3);
        check("wrap_hit", {r, g, b}, 'h3f, 1'b1);

        fg_rgb = 6'b011011; bg_rgb = 6'b100100;
        for (int md = 1; md < 4; md++) begin
            mode = 2'(md); arms = 2'(md);
            do_tick();
            for (int k = 0; k < 24; k++) begin
                @(negedge clk);
                angle = 4'(k);
                radius = 5'((k * 5 + md) % 32);
                display_on_in = ((k % 7) != 0);
            end
        end
        display_on_in = 1'b1;
        cyc(4);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rst_frame", frame_cnt, 0, 1'b1);
        check("async_rst_rgb", {r, g, b}, 0, 1'b1);
        cyc(2);
        reset = 1'b0;

        speed = 3'd0; dir = 1'b0; arms = 2'd2; mode = 2'd0;
        fg_rgb = 6'h3f; bg_rgb = 6'h15; angle = 4'd3; radius = 5'd12;
        cyc(4);
        check("black_before_tick", {r, g, b}, 0, 1'b1);
        do_tick(); cyc(2);
        check("arms4_hit", {r, g, b}, 'h3f, 1'b1);
        radius = 5'd13;
        cyc(4);
        check("arms4_miss", {r, g, b}, 'h15, 1'b1);

        arms = 2'd0; mode = 2'd2;
        do_tick();
        angle = 4'd8; radius = 5'd0;
        cyc(4);
        check("rays_hit", {r, g, b}, 'h3f, 1'b1);
        angle = 4'd7;
        cyc(4);
        check("rays_miss", {r, g, b}, 'h15, 1'b1);

        mode = 2'd0;
        do_tick();
        angle = 4'd5; radius = 5'b10101;
        cyc(4);
`ifdef SPIRAL_CLIP_EN
        check("clip_outer", {r, g, b}, 'h15, 1'b1);
`else
        check("repeat_outer", {r, g, b}, 'h3f, 1'b1);
`endif
        display_on_in = 1'b0;
        cyc(4);
        check("blank", {r, g, b}, 0, 1'b1);

        repeat (256) do_tick();
        cyc(2);
        check("frame_wrap", frame_cnt, 3, 1'b1);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
